// File: rtl/memory_arbiter.sv
//==============================================================================
// Module   : memory_arbiter
// Summary  : Shares one single-ported RAM bus between instruction fetch and
//            data load/store. Data has priority, and both results are buffered.
// Options  : MEM_ARB_SNOOP_INVAL_EN invalidates the instruction buffer when a
//            data store hits the buffered word.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dren,
    input  logic              dwen,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_store_q, ram_store_d;
    logic [DATA_W-1:0] iload_q, iload_d;
    logic [DATA_W-1:0] dload_q, dload_d;
    logic [ADDR_W-1:0] ibuf_addr_q, ibuf_addr_d;
    logic              ibuf_valid_q, ibuf_valid_d;
    logic              dbuf_valid_q, dbuf_valid_d;
    logic              dreq;

    assign dreq      = dren | dwen;
    assign ihit      = iren & ibuf_valid_q & (ibuf_addr_q == iaddr);
    assign dhit      = dbuf_valid_q & dreq;
    assign iload     = iload_q;
    assign dload     = dload_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_store = ram_store_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_store_q  <= '0;
            iload_q      <= '0;
            dload_q      <= '0;
            ibuf_addr_q  <= '0;
            ibuf_valid_q <= 1'b0;
            dbuf_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
            ram_addr_q   <= ram_addr_d;
            ram_store_q  <= ram_store_d;
            iload_q      <= iload_d;
            dload_q      <= dload_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_valid_q <= ibuf_valid_d;
            dbuf_valid_q <= dbuf_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ram_ren_d    = ram_ren_q;
        ram_wen_d    = ram_wen_q;
        ram_addr_d   = ram_addr_q;
        ram_store_d  = ram_store_q;
        iload_d      = iload_q;
        dload_d      = dload_q;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_valid_d = ibuf_valid_q;
        dbuf_valid_d = dbuf_valid_q;

        // Data result is consumed once the pipeline advances or drops the request
        if ((ihit & dhit) | ~dreq) begin
            dbuf_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                ram_ren_d = 1'b0;
                ram_wen_d = 1'b0;
                if (dreq & ~dbuf_valid_q) begin
                    state_d     = DACC;
                    ram_addr_d  = daddr;
                    ram_store_d = dstore;
                    ram_ren_d   = dren;
                    ram_wen_d   = dwen;
                end else if (iren & ~ihit) begin
                    state_d      = IACC;
                    ram_addr_d   = iaddr;
                    ram_ren_d    = 1'b1;
                    ibuf_addr_d  = iaddr;
                    ibuf_valid_d = 1'b0;
                end
            end
            DACC: begin
                if (ram_ready) begin
                    if (ram_ren_q) begin
                        dload_d = ram_load;
                    end
`ifdef MEM_ARB_SNOOP_INVAL_EN
                    // Word-granular match keeps self-modifying code coherent
                    if (ram_wen_q && (ram_addr_q[ADDR_W-1:2] == ibuf_addr_q[ADDR_W-1:2])) begin
                        ibuf_valid_d = 1'b0;
                    end
`endif
                    dbuf_valid_d = 1'b1;
                    ram_ren_d    = 1'b0;
                    ram_wen_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            IACC: begin
                if (ram_ready) begin
                    iload_d      = ram_load;
                    ibuf_valid_d = 1'b1;
                    ram_ren_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
//==============================================================================
// Module   : tb_memory_arbiter
// Summary  : Directed self-checking bench for memory_arbiter with a RAM responder.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iren = 1'b0;
    logic [31:0] iaddr = '0;
    logic        ihit;
    logic [31:0] iload;
    logic        dren = 1'b0;
    logic        dwen = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dhit;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load = '0;
    logic        ram_ready = 1'b0;

    logic        resp_en = 1'b1;
    int          resp_wait = 0;
    int          wcnt = 0;
    logic        man_ready = 1'b0;
    logic [31:0] man_load = '0;
    logic [31:0] mem400 = 32'h4444_4444;
    logic [31:0] exp_i;

    int n_chk = 0;
    int n_err = 0;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .iren      (iren),
        .iaddr     (iaddr),
        .ihit      (ihit),
        .iload     (iload),
        .dren      (dren),
        .dwen      (dwen),
        .daddr     (daddr),
        .dstore    (dstore),
        .dhit      (dhit),
        .dload     (dload),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_rd = 32'hDEAD_BEEF;
            32'h0000_0104: mem_rd = 32'h0BAD_C0DE;
            32'h0000_0200: mem_rd = 32'h2222_2222;
            32'h0000_0300: mem_rd = 32'h3333_3333;
            32'h0000_0400: mem_rd = mem400;
            32'h0000_2000: mem_rd = 32'hCAFE_F00D;
            32'h0000_5000: mem_rd = 32'h5050_5050;
            default:       mem_rd = ~a;
        endcase
    endfunction

    // RAM model: completes each strobed access after resp_wait wait cycles
    always @(negedge clk) begin
        if (!resp_en) begin
            ram_ready <= man_ready;
            ram_load  <= man_load;
            wcnt      <= 0;
        end else if (ram_ready) begin
            ram_ready <= 1'b0;
            wcnt      <= 0;
        end else if (ram_ren || ram_wen) begin
            if (wcnt == resp_wait) begin
                ram_ready <= 1'b1;
                if (ram_ren) ram_load <= mem_rd(ram_addr);
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk_eq("rst_ihit", ihit, 0);
        chk_eq("rst_dhit", dhit, 0);
        chk_eq("rst_ren", ram_ren, 0);
        chk_eq("rst_wen", ram_wen, 0);
        chk_eq("rst_addr", ram_addr, 0);
        chk_eq("rst_store", ram_store, 0);
        chk_eq("rst_iload", iload, 0);
        chk_eq("rst_dload", dload, 0);
        rst = 1'b0;

        // Fetch 0x100, zero wait states
        resp_wait = 0;
        iren = 1'b1; iaddr = 32'h100;
        tick();
        chk_eq("f_ren", ram_ren, 1);
        chk_eq("f_addr", ram_addr, 32'h100);
        chk_eq("f_ihit0", ihit, 0);
        tick();
        chk_eq("f_ihit", ihit, 1);
        chk_eq("f_iload", iload, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_eq("f_norefetch", ram_ren, 0);
            chk_eq("f_ihold", ihit, 1);
        end

        // Load 0x2000 with 0x104 unbuffered, two wait states each
        resp_wait = 2;
        iaddr = 32'h104; dren = 1'b1; daddr = 32'h2000;
        tick();
        chk_eq("ld_ren", ram_ren, 1);
        chk_eq("ld_wen", ram_wen, 0);
        chk_eq("ld_addr", ram_addr, 32'h2000);
        tick();
        tick();
        tick();
        chk_eq("ld_dhit", dhit, 1);
        chk_eq("ld_dload", dload, 32'hCAFE_F00D);
        chk_eq("ld_ihit0", ihit, 0);
        chk_eq("ld_renlow", ram_ren, 0);
        tick();
        chk_eq("ld_iacc_ren", ram_ren, 1);
        chk_eq("ld_iacc_addr", ram_addr, 32'h104);
        chk_eq("ld_dhit_hold", dhit, 1);
        tick();
        tick();
        tick();
        chk_eq("ld_both_i", ihit, 1);
        chk_eq("ld_both_d", dhit, 1);
        chk_eq("ld_iload", iload, 32'h0BAD_C0DE);
        tick();
        chk_eq("ld_dhit_gone", dhit, 0);
        chk_eq("ld_ihit_keep", ihit, 1);

        // Store 0x3000, one wait state
        resp_wait = 1;
        dren = 1'b0; dwen = 1'b1; daddr = 32'h3000; dstore = 32'h1234_5678;
        tick();
        chk_eq("st_wen", ram_wen, 1);
        chk_eq("st_ren", ram_ren, 0);
        chk_eq("st_addr", ram_addr, 32'h3000);
        chk_eq("st_data", ram_store, 32'h1234_5678);
        tick();
        chk_eq("st_wen_hold", ram_wen, 1);
        chk_eq("st_addr_hold", ram_addr, 32'h3000);
        tick();
        chk_eq("st_wen_low", ram_wen, 0);
        chk_eq("st_dhit", dhit, 1);
        chk_eq("st_dload", dload, 32'hCAFE_F00D);
        dwen = 1'b0;

        // Branch: iaddr moves 0x200 -> 0x300 while the fetch is in flight
        resp_wait = 2;
        iaddr = 32'h200;
        tick();
        chk_eq("br_ren", ram_ren, 1);
        chk_eq("br_addr", ram_addr, 32'h200);
        iaddr = 32'h300;
        tick();
        chk_eq("br_addr_hold", ram_addr, 32'h200);
        tick();
        tick();
        chk_eq("br_ihit0", ihit, 0);
        chk_eq("br_renlow", ram_ren, 0);
        tick();
        chk_eq("br_ren2", ram_ren, 1);
        chk_eq("br_addr2", ram_addr, 32'h300);
        tick();
        tick();
        tick();
        chk_eq("br_ihit", ihit, 1);
        chk_eq("br_iload", iload, 32'h3333_3333);

        // Store onto the buffered instruction word
        resp_wait = 0;
        iaddr = 32'h400;
        tick();
        chk_eq("sn_ren", ram_ren, 1);
        tick();
        chk_eq("sn_ihit", ihit, 1);
        chk_eq("sn_iload", iload, 32'h4444_4444);
        dwen = 1'b1; daddr = 32'h400; dstore = 32'h5555_5555;
        mem400 = 32'h5555_5555;
        tick();
        chk_eq("sn_wen", ram_wen, 1);
        tick();
        chk_eq("sn_dhit", dhit, 1);
`ifdef MEM_ARB_SNOOP_INVAL_EN
        chk_eq("sn_inval", ihit, 0);
        tick();
        chk_eq("sn_refetch_ren", ram_ren, 1);
        chk_eq("sn_refetch_addr", ram_addr, 32'h400);
        tick();
        chk_eq("sn_both_i", ihit, 1);
        chk_eq("sn_both_d", dhit, 1);
        chk_eq("sn_new_iload", iload, 32'h5555_5555);
        exp_i = 32'h5555_5555;
`else
        chk_eq("sn_stale_ihit", ihit, 1);
        chk_eq("sn_stale_iload", iload, 32'h4444_4444);
        exp_i = 32'h4444_4444;
`endif
        dwen = 1'b0;

        // ram_ready asserted while idle must be ignored
        resp_en = 1'b0; man_ready = 1'b1; man_load = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_eq("idle_ren", ram_ren, 0);
            chk_eq("idle_iload", iload, exp_i);
            chk_eq("idle_dload", dload, 32'hCAFE_F00D);
        end
        man_ready = 1'b0;
        tick();

        // Reset in the middle of a data access with ram_ready low
        iren = 1'b0; dren = 1'b1; daddr = 32'h5000;
        tick();
        chk_eq("ra_ren", ram_ren, 1);
        chk_eq("ra_addr", ram_addr, 32'h5000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_eq("ra_ren0", ram_ren, 0);
        chk_eq("ra_addr0", ram_addr, 0);
        chk_eq("ra_iload0", iload, 0);
        chk_eq("ra_dload0", dload, 0);
        chk_eq("ra_dhit0", dhit, 0);
        tick();
        rst = 1'b0;
        resp_en = 1'b1; resp_wait = 0;
        tick();
        chk_eq("pr_ren", ram_ren, 1);
        chk_eq("pr_addr", ram_addr, 32'h5000);
        tick();
        chk_eq("pr_dhit", dhit, 1);
        chk_eq("pr_dload", dload, 32'h5050_5050);
        dren = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
